// File: rtl/he_hssi_csr_pkg.sv
// he_hssi_csr_pkg: register addresses, CMD bit positions and tg transaction states.
package he_hssi_csr_pkg;
  localparam logic [15:0] ADDR_DFH      = 16'h0000;
  localparam logic [15:0] ADDR_AFU_ID_L = 16'h0008;
  localparam logic [15:0] ADDR_AFU_ID_H = 16'h0010;
  localparam logic [15:0] ADDR_CMD      = 16'h0030;
  localparam logic [15:0] ADDR_DATA     = 16'h0038;
  localparam logic [15:0] ADDR_CH_SEL   = 16'h0040;
  localparam logic [15:0] ADDR_SCRATCH  = 16'h0048;
  localparam logic [15:0] ADDR_XBAR     = 16'h0050;
  localparam logic [15:0] ADDR_LINK     = 16'h0058;
  localparam int CMD_RD   = 16;
  localparam int CMD_WR   = 17;
  localparam int CMD_ACK  = 32;
  localparam int CMD_ERR  = 33;
  localparam int CMD_BUSY = 34;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, DONE} tg_state_e;
endpackage

// File: rtl/he_hssi_tg_xact.sv
// he_hssi_tg_xact: traffic-generator transaction FSM with timeout and status flags.
module he_hssi_tg_xact
  import he_hssi_csr_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        bad,
  input  logic        is_rd,
  input  logic        tg_waitrequest,
  input  logic [31:0] tg_rdata,
  input  logic        tg_rdata_valid,
  output logic        tg_wr,
  output logic        tg_rd,
  output logic        ack,
  output logic        err,
  output logic        busy,
  output logic [31:0] rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  tg_state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic ack_n, err_n, busy_n, tout;
  logic [31:0] rdata_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      ack   <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ack   <= ack_n;
      err   <= err_n;
      busy  <= busy_n;
      rdata <= rdata_n;
    end
  // Timeout takes priority: strobes drop in the same cycle the limit is reached.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ack_n   = ack;
    err_n   = err;
    busy_n  = busy;
    rdata_n = rdata;
    tg_rd   = 1'b0;
    tg_wr   = 1'b0;
    tout    = (state == REQ || state == WAIT_RD) && cnt == CW'(TIMEOUT);
    case (state)
      IDLE:
        if (start) begin
          state_n = REQ;
          cnt_n   = '0;
          ack_n   = 1'b0;
          err_n   = 1'b0;
          busy_n  = 1'b1;
        end else if (bad) begin
          err_n = 1'b1;
          ack_n = 1'b0;
        end
      REQ: begin
        cnt_n = cnt + 1'b1;
        tg_rd = is_rd;
        tg_wr = !is_rd;
        if (!tg_waitrequest) state_n = is_rd ? WAIT_RD : DONE;
      end
      WAIT_RD: begin
        cnt_n = cnt + 1'b1;
        if (tg_rdata_valid) begin
          rdata_n = tg_rdata;
          state_n = DONE;
        end
      end
      default: begin
        ack_n   = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
    if (tout) begin
      state_n = IDLE;
      rdata_n = rdata;
      ack_n   = 1'b1;
      err_n   = 1'b1;
      busy_n  = 1'b0;
      tg_rd   = 1'b0;
      tg_wr   = 1'b0;
    end
  end
endmodule

// File: rtl/he_hssi_afu_csr.sv
// he_hssi_afu_csr: HSSI AFU CSR block with registered reads and a traffic-generator command port.
module he_hssi_afu_csr
  import he_hssi_csr_pkg::*;
#(
  parameter logic [63:0] DFH      = 64'h1000_0000_1000_0000,
  parameter logic [63:0] AFU_ID_L = 64'h0,
  parameter logic [63:0] AFU_ID_H = 64'h0,
  parameter int          NUM_CH   = 8,
  parameter int          TIMEOUT  = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] csr_addr,
  input  logic        csr_wr,
  input  logic [63:0] csr_wr_data,
  output logic [63:0] csr_rd_data,
  output logic [3:0]  tg_ch,
  output logic [15:0] tg_addr,
  output logic        tg_wr,
  output logic        tg_rd,
  output logic [31:0] tg_wdata,
  input  logic        tg_waitrequest,
  input  logic [31:0] tg_rdata,
  input  logic        tg_rdata_valid,
  input  logic [15:0] link_status_i,
  output logic        crossbar_en_o
);
  localparam logic [15:0] LINK_MASK = NUM_CH >= 16 ? 16'hFFFF : 16'((32'd1 << NUM_CH) - 1);
  logic [15:0] cmd_addr;
  logic        cmd_rd, cmd_wr, xbar, ack, err, busy, cmd_ok, one_op;
  logic [31:0] data_w, rdata;
  logic [3:0]  ch_sel;
  logic [63:0] scratch, rd_mux;
  assign cmd_ok        = csr_wr && !busy && csr_addr == ADDR_CMD;
  assign one_op        = csr_wr_data[CMD_RD] ^ csr_wr_data[CMD_WR];
  assign tg_addr       = cmd_addr;
  assign tg_wdata      = data_w;
  assign tg_ch         = ch_sel;
  assign crossbar_en_o = xbar;
  always_comb begin
    rd_mux = '0;
    case (csr_addr)
      ADDR_DFH:      rd_mux = DFH;
      ADDR_AFU_ID_L: rd_mux = AFU_ID_L;
      ADDR_AFU_ID_H: rd_mux = AFU_ID_H;
      ADDR_CMD:      rd_mux = {29'b0, busy, err, ack, 14'b0, cmd_wr, cmd_rd, cmd_addr};
      ADDR_DATA:     rd_mux = {rdata, data_w};
      ADDR_CH_SEL:   rd_mux = {60'b0, ch_sel};
      ADDR_SCRATCH:  rd_mux = scratch;
      ADDR_XBAR:     rd_mux = {63'b0, xbar};
      ADDR_LINK:     rd_mux = {48'b0, link_status_i & LINK_MASK};
      default:       rd_mux = '0;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cmd_addr    <= '0;
      cmd_rd      <= 1'b0;
      cmd_wr      <= 1'b0;
      data_w      <= '0;
      ch_sel      <= '0;
      scratch     <= '0;
      xbar        <= 1'b0;
      csr_rd_data <= '0;
    end else begin
      csr_rd_data <= rd_mux;
      if (cmd_ok) begin
        cmd_addr <= csr_wr_data[15:0];
        cmd_rd   <= csr_wr_data[CMD_RD];
        cmd_wr   <= csr_wr_data[CMD_WR];
      end
      if (csr_wr && !busy && csr_addr == ADDR_DATA) data_w <= csr_wr_data[31:0];
      if (csr_wr && !busy && csr_addr == ADDR_CH_SEL && csr_wr_data < 64'(NUM_CH)) ch_sel <= csr_wr_data[3:0];
      if (csr_wr && csr_addr == ADDR_SCRATCH) scratch <= csr_wr_data;
      if (csr_wr && csr_addr == ADDR_XBAR) xbar <= csr_wr_data[0];
    end
  he_hssi_tg_xact #(.TIMEOUT(TIMEOUT)) u_xact (
    .clk            (clk),
    .reset          (reset),
    .start          (cmd_ok && one_op),
    .bad            (cmd_ok && !one_op),
    .is_rd          (cmd_rd),
    .tg_waitrequest (tg_waitrequest),
    .tg_rdata       (tg_rdata),
    .tg_rdata_valid (tg_rdata_valid),
    .tg_wr          (tg_wr),
    .tg_rd          (tg_rd),
    .ack            (ack),
    .err            (err),
    .busy           (busy),
    .rdata          (rdata)
  );
endmodule

// File: tb/tb_he_hssi_afu_csr.sv
// tb_he_hssi_afu_csr: directed checks of the CSR map and tg transaction flow.
module tb_he_hssi_afu_csr;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] csr_addr;
  logic        csr_wr;
  logic [63:0] csr_wr_data;
  logic [63:0] csr_rd_data;
  logic [3:0]  tg_ch;
  logic [15:0] tg_addr;
  logic        tg_wr, tg_rd;
  logic [31:0] tg_wdata;
  logic        tg_waitrequest;
  logic [31:0] tg_rdata;
  logic        tg_rdata_valid;
  logic [15:0] link_status_i;
  logic        crossbar_en_o;
  int checks = 0;
  int failures = 0;
  logic [63:0] v;
  int n, total;
  logic seen;

  he_hssi_afu_csr dut (
    .clk            (clk),
    .reset          (reset),
    .csr_addr       (csr_addr),
    .csr_wr         (csr_wr),
    .csr_wr_data    (csr_wr_data),
    .csr_rd_data    (csr_rd_data),
    .tg_ch          (tg_ch),
    .tg_addr        (tg_addr),
    .tg_wr          (tg_wr),
    .tg_rd          (tg_rd),
    .tg_wdata       (tg_wdata),
    .tg_waitrequest (tg_waitrequest),
    .tg_rdata       (tg_rdata),
    .tg_rdata_valid (tg_rdata_valid),
    .link_status_i  (link_status_i),
    .crossbar_en_o  (crossbar_en_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic csr_write(input logic [15:0] a, input logic [63:0] d);
    @(negedge clk);
    csr_addr = a;
    csr_wr = 1'b1;
    csr_wr_data = d;
    @(negedge clk);
    csr_wr = 1'b0;
  endtask

  task automatic csr_read(input logic [15:0] a, output logic [63:0] r);
    @(negedge clk);
    csr_addr = a;
    @(negedge clk);
    r = csr_rd_data;
  endtask

  initial begin
    csr_addr = '0;
    csr_wr = 1'b0;
    csr_wr_data = '0;
    tg_waitrequest = 1'b0;
    tg_rdata = '0;
    tg_rdata_valid = 1'b0;
    link_status_i = '0;
    repeat (2) @(negedge clk);
    chk("reset_rd_data", csr_rd_data, 64'h0);
    chk("reset_outputs", {6'b0, tg_wr, tg_rd, crossbar_en_o, tg_ch, tg_addr, tg_wdata}, 64'h0);
    reset = 1'b0;
    // Register map basics
    csr_read(16'h0000, v); chk("dfh", v, 64'h1000_0000_1000_0000);
    csr_read(16'h0008, v); chk("afu_id_l", v, 64'h0);
    csr_read(16'h0020, v); chk("unmapped_0x20", v, 64'h0);
    csr_write(16'h0048, 64'hDEAD_BEEF_0123_4567);
    csr_read(16'h0048, v); chk("scratch", v, 64'hDEAD_BEEF_0123_4567);
    csr_write(16'h0050, 64'hF);
    csr_read(16'h0050, v); chk("xbar_read", v, 64'h1);
    chk("crossbar_en_o", {63'b0, crossbar_en_o}, 64'h1);
    link_status_i = 16'hA35C;
    csr_read(16'h0058, v); chk("link_masked", v, 64'h5C);
    csr_write(16'h0040, 64'h3);
    csr_write(16'h0040, 64'h8);
    csr_read(16'h0040, v); chk("ch_sel_oob_ignored", v, 64'h3);
    csr_write(16'h0040, 64'h1_0000_0005);
    csr_read(16'h0040, v); chk("ch_sel_wide_ignored", v, 64'h3);
    csr_write(16'h0038, 64'hFFFF_FFFF_0000_A5A5);
    csr_read(16'h0038, v); chk("data_rdata_ro", v, 64'h0000_0000_0000_A5A5);
    // Write transaction with 3 cycles of waitrequest
    tg_waitrequest = 1'b1;
    csr_write(16'h0030, 64'h2_0010);
    chk("wr_req_fields", {28'b0, tg_ch, tg_addr, tg_wdata}, {28'b0, 4'h3, 16'h0010, 32'h0000_A5A5});
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tg_wr) n++;
      if (tg_rd) seen = 1'b1;
      if (n == 4) tg_waitrequest = 1'b0;
      if (!tg_wr && n > 0) break;
      @(negedge clk);
    end
    chk("wr_strobe_cycles", 64'(n), 64'd4);
    chk("wr_no_rd_strobe", {63'b0, seen}, 64'h0);
    @(negedge clk);
    csr_read(16'h0030, v); chk("wr_ack", v, 64'h0000_0001_0002_0010);
    // Read transaction, data returned after 5 cycles
    csr_write(16'h0030, 64'h1_0020);
    chk("rd_strobe", {47'b0, tg_rd, tg_addr}, {47'b0, 1'b1, 16'h0020});
    csr_read(16'h0030, v); chk("rd_busy", v, 64'h0000_0004_0001_0020);
    repeat (3) @(negedge clk);
    tg_rdata = 32'h1234;
    tg_rdata_valid = 1'b1;
    @(negedge clk);
    tg_rdata_valid = 1'b0;
    tg_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    csr_read(16'h0030, v); chk("rd_ack", v, 64'h0000_0001_0001_0020);
    csr_read(16'h0038, v); chk("rd_data", v, 64'h0000_1234_0000_A5A5);
    // Read that never returns: timeout, writes while busy ignored
    csr_write(16'h0030, 64'h1_0030);
    csr_write(16'h0030, 64'h2_0055);
    csr_write(16'h0038, 64'hFFFF);
    csr_addr = 16'h0030;
    @(negedge clk);
    total = 3;
    n = 0;
    while (csr_rd_data[34] !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    total += n;
    chk("timeout_window", 64'(total >= 1020 && total <= 1030), 64'h1);
    chk("timeout_cmd", csr_rd_data, 64'h0000_0003_0001_0030);
    chk("timeout_strobes", {62'b0, tg_rd, tg_wr}, 64'h0);
    csr_read(16'h0038, v); chk("busy_data_ignored", v, 64'h0000_1234_0000_A5A5);
    // Reset during WAIT_RD, then an invalid command
    csr_write(16'h0030, 64'h1_0040);
    @(negedge clk);
    chk("wait_rd_no_strobe", {63'b0, tg_rd}, 64'h0);
    reset = 1'b1;
    #1;
    chk("async_reset", {61'b0, tg_rd, crossbar_en_o, |csr_rd_data}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    csr_read(16'h0030, v); chk("reset_cmd", v, 64'h0);
    csr_read(16'h0048, v); chk("reset_scratch", v, 64'h0);
    csr_write(16'h0030, 64'h3_0000);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (tg_rd || tg_wr) seen = 1'b1;
      @(negedge clk);
    end
    chk("bad_no_strobe", {63'b0, seen}, 64'h0);
    csr_read(16'h0030, v); chk("bad_err", v, 64'h0000_0002_0003_0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
